// File: rtl/adder_result_rcv.sv
// Receives adder results into a small first-word-fall-through FIFO and tracks
// outstanding operations so the operand driver never over-issues.
module adder_result_rcv #(
  parameter int OUTPUT_DATA_WIDTH = 33,
  parameter int DEPTH             = 4,
  parameter int CNT_WIDTH         = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          inputs_valid,
  input  logic                          output_valid,
  input  logic [OUTPUT_DATA_WIDTH-1:0]  out,
  output logic                          issue_ok,
  output logic                          m_valid,
  output logic [OUTPUT_DATA_WIDTH-1:0]  m_data,
  input  logic                          m_ready,
  output logic [$clog2(DEPTH):0]        fill_level,
  output logic [$clog2(DEPTH):0]        in_flight,
  output logic                          overflow,
  output logic [CNT_WIDTH-1:0]          result_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [OUTPUT_DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]                wptr;
  logic [AW-1:0]                rptr;
  logic                         full;
  logic                         pop;
  logic                         push;
  logic [LW:0]                  occupancy;

  assign full     = (fill_level == FULL_LVL);
  assign m_valid  = (fill_level != '0);
  assign pop      = m_valid & m_ready;
  assign push     = output_valid & (~full | pop);
  assign m_data   = m_valid ? mem[rptr] : '0;

  // Counts slots already promised to in-flight results; a same-cycle pop is
  // deliberately ignored so the decision depends on registers only.
  assign occupancy = {1'b0, fill_level} + {1'b0, in_flight};
  assign issue_ok  = (occupancy < {1'b0, FULL_LVL});

  // Storage carries no reset; m_data is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= out;
    end
  end

  // Pointers are AW bits wide with DEPTH a power of two, so they wrap naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr         <= '0;
      rptr         <= '0;
      fill_level   <= '0;
      in_flight    <= '0;
      overflow     <= 1'b0;
      result_count <= '0;
    end else begin
      if (push) begin
        wptr         <= wptr + 1'b1;
        result_count <= result_count + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      if (push && !pop) begin
        fill_level <= fill_level + 1'b1;
      end else if (pop && !push) begin
        fill_level <= fill_level - 1'b1;
      end

      if (inputs_valid && !output_valid) begin
        if (in_flight != FULL_LVL) begin
          in_flight <= in_flight + 1'b1;
        end
      end else if (output_valid && !inputs_valid) begin
        if (in_flight != '0) begin
          in_flight <= in_flight - 1'b1;
        end
      end

      if (output_valid && full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_adder_result_rcv.sv
// Directed bench for adder_result_rcv (DEPTH=4): a vector table for the main
// flow plus hand sequences for async reset, drain order and pointer wrap.
module tb_adder_result_rcv;

  logic        clk;
  logic        reset;
  logic        inputs_valid;
  logic        output_valid;
  logic [32:0] out;
  logic        issue_ok;
  logic        m_valid;
  logic [32:0] m_data;
  logic        m_ready;
  logic [2:0]  fill_level;
  logic [2:0]  in_flight;
  logic        overflow;
  logic [15:0] result_count;

  int unsigned tests;
  int unsigned fails;

  adder_result_rcv #(
    .OUTPUT_DATA_WIDTH(33),
    .DEPTH(4),
    .CNT_WIDTH(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .inputs_valid(inputs_valid),
    .output_valid(output_valid),
    .out(out),
    .issue_ok(issue_ok),
    .m_valid(m_valid),
    .m_data(m_data),
    .m_ready(m_ready),
    .fill_level(fill_level),
    .in_flight(in_flight),
    .overflow(overflow),
    .result_count(result_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic        ov;
    logic        mr;
    logic [32:0] dat;
    logic        mv;
    logic [32:0] md;
    logic [2:0]  fl;
    logic [2:0]  inf;
    logic        ok;
    logic        ovf;
    logic [15:0] cnt;
  } vec_t;

  vec_t vt[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic iv, input logic ov, input logic mr, input logic [32:0] dat,
                     input logic mv, input logic [32:0] md, input logic [2:0] fl,
                     input logic [2:0] inf, input logic ok, input logic ovf,
                     input logic [15:0] cnt);
    vec_t v;
    v.iv = iv; v.ov = ov; v.mr = mr; v.dat = dat;
    v.mv = mv; v.md = md; v.fl = fl; v.inf = inf; v.ok = ok; v.ovf = ovf; v.cnt = cnt;
    vt.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic ov, input logic mr, input logic [32:0] dat);
    inputs_valid = iv;
    output_valid = ov;
    m_ready      = mr;
    out          = dat;
  endtask

  // Pulse reset between clock edges and leave the bench one ns after a posedge.
  task automatic reset_pulse();
    drive(1'b0, 1'b0, 1'b0, '0);
    #2 reset = 1'b0;
    #2 reset = 1'b1;
    step();
  endtask

  initial begin
    logic [32:0] q[$];
    logic [32:0] v33;
    int unsigned guard;

    tests = 0;
    fails = 0;
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0);

    #12;
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_m_data", 64'(m_data), 64'd0);
    check("rst_fill", 64'(fill_level), 64'd0);
    check("rst_inflight", 64'(in_flight), 64'd0);
    check("rst_issue_ok", 64'(issue_ok), 64'd1);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_count", 64'(result_count), 64'd0);
    reset = 1'b1;

    //   iv ov mr dat   mv md fl if ok ovf cnt
    add(1, 0, 0, 0,    0, 0, 0, 1, 1, 0, 0);
    add(1, 0, 0, 0,    0, 0, 0, 2, 1, 0, 0);
    add(1, 0, 0, 0,    0, 0, 0, 3, 1, 0, 0);
    add(1, 0, 0, 0,    0, 0, 0, 4, 0, 0, 0);
    add(0, 1, 0, 1,    1, 1, 1, 3, 0, 0, 1);
    add(0, 1, 0, 2,    1, 1, 2, 2, 0, 0, 2);
    add(0, 1, 0, 3,    1, 1, 3, 1, 0, 0, 3);
    add(0, 1, 0, 4,    1, 1, 4, 0, 0, 0, 4);
    add(0, 1, 1, 5,    1, 2, 4, 0, 0, 0, 5);
    add(0, 1, 0, 6,    1, 2, 4, 0, 0, 1, 5);
    add(0, 0, 1, 0,    1, 3, 3, 0, 1, 1, 5);
    add(0, 0, 1, 0,    1, 4, 2, 0, 1, 1, 5);
    add(0, 0, 1, 0,    1, 5, 1, 0, 1, 1, 5);
    add(0, 1, 1, 7,    1, 7, 1, 0, 1, 1, 6);
    add(0, 0, 1, 0,    0, 0, 0, 0, 1, 1, 6);
    add(1, 1, 0, 8,    1, 8, 1, 0, 1, 1, 7);
    add(0, 0, 1, 0,    0, 0, 0, 0, 1, 1, 7);
    add(1, 0, 0, 0,    0, 0, 0, 1, 1, 1, 7);
    add(1, 0, 0, 0,    0, 0, 0, 2, 1, 1, 7);
    add(1, 0, 0, 0,    0, 0, 0, 3, 1, 1, 7);
    add(1, 0, 0, 0,    0, 0, 0, 4, 0, 1, 7);
    add(1, 0, 0, 0,    0, 0, 0, 4, 0, 1, 7);
    add(0, 1, 0, 9,    1, 9, 1, 3, 0, 1, 8);

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].iv, vt[i].ov, vt[i].mr, vt[i].dat);
      step();
      check($sformatf("v%0d_m_valid", i), 64'(m_valid), 64'(vt[i].mv));
      check($sformatf("v%0d_m_data", i), 64'(m_data), 64'(vt[i].md));
      check($sformatf("v%0d_fill", i), 64'(fill_level), 64'(vt[i].fl));
      check($sformatf("v%0d_inflight", i), 64'(in_flight), 64'(vt[i].inf));
      check($sformatf("v%0d_issue_ok", i), 64'(issue_ok), 64'(vt[i].ok));
      check($sformatf("v%0d_overflow", i), 64'(overflow), 64'(vt[i].ovf));
      check($sformatf("v%0d_count", i), 64'(result_count), 64'(vt[i].cnt));
    end

    // Mid-stream async reset: reach fill_level=2, in_flight=1 first.
    drive(1'b0, 1'b1, 1'b0, 33'hA);
    step();
    drive(1'b0, 1'b1, 1'b0, 33'hB);
    step();
    drive(1'b0, 1'b0, 1'b1, '0);
    step();
    drive(1'b0, 1'b0, 1'b0, '0);
    check("mid_pre_fill", 64'(fill_level), 64'd2);
    check("mid_pre_inflight", 64'(in_flight), 64'd1);
    #2 reset = 1'b0;
    #1;
    check("mid_m_valid", 64'(m_valid), 64'd0);
    check("mid_m_data", 64'(m_data), 64'd0);
    check("mid_fill", 64'(fill_level), 64'd0);
    check("mid_inflight", 64'(in_flight), 64'd0);
    check("mid_issue_ok", 64'(issue_ok), 64'd1);
    check("mid_overflow", 64'(overflow), 64'd0);
    check("mid_count", 64'(result_count), 64'd0);
    #2 reset = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 33'h55);
    step();
    check("late_inflight", 64'(in_flight), 64'd0);
    check("late_fill", 64'(fill_level), 64'd1);
    check("late_m_data", 64'(m_data), 64'h55);
    check("late_count", 64'(result_count), 64'd1);

    // Three results, then a continuous drain.
    reset_pulse();
    for (int k = 1; k <= 3; k++) begin
      drive(1'b0, 1'b1, 1'b0, 33'(k));
      step();
    end
    drive(1'b0, 1'b0, 1'b1, '0);
    for (int k = 1; k <= 3; k++) begin
      check($sformatf("drain%0d_m_valid", k), 64'(m_valid), 64'd1);
      check($sformatf("drain%0d_m_data", k), 64'(m_data), 64'(k));
      step();
    end
    check("drain_m_valid_low", 64'(m_valid), 64'd0);
    check("drain_count", 64'(result_count), 64'd3);

    // Six wide results with interleaved pops; pointers wrap past DEPTH-1.
    for (int i = 0; i < 6; i++) begin
      v33 = 33'h1_0000_0100 + 33'(i);
      drive(1'b0, 1'b1, 1'(i % 2), v33);
      check($sformatf("wrap%0d_m_valid", i), 64'(m_valid), 64'(q.size() != 0));
      if (q.size() != 0) begin
        check($sformatf("wrap%0d_m_data", i), 64'(m_data), 64'(q[0]));
        if (i % 2 == 1) void'(q.pop_front());
      end
      q.push_back(v33);
      step();
    end
    drive(1'b0, 1'b0, 1'b1, '0);
    guard = 0;
    while (q.size() != 0 && guard < 8) begin
      check($sformatf("wdrain%0d_m_data", guard), 64'(m_data), 64'(q[0]));
      void'(q.pop_front());
      step();
      guard++;
    end
    check("wrap_empty", 64'(m_valid), 64'd0);
    check("wrap_fill", 64'(fill_level), 64'd0);
    check("wrap_count", 64'(result_count), 64'd9);
    check("wrap_overflow", 64'(overflow), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/adder_result_rcv.md
ADDER_RESULT_RCV -- requirements
Module: adder_result_rcv

Interface
REQ-001 Parameter OUTPUT_DATA_WIDTH, default 33, width of adder result and buffered data.
REQ-002 Parameter DEPTH, default 4, result FIFO entries; power of two, 2..16.
REQ-003 Parameter CNT_WIDTH, default 16, width of result_count.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 inputs_valid  input  1  adder accepted one operand pair this cycle (operation issued).
REQ-007 output_valid  input  1  adder presents one valid result on out this cycle; no backpressure to adder.
REQ-008 out  input  OUTPUT_DATA_WIDTH  adder result, sampled only when output_valid=1.
REQ-009 issue_ok  output  1  operand driver may assert inputs_valid this cycle.
REQ-010 m_valid  output  1  buffered result available downstream.
REQ-011 m_data  output  OUTPUT_DATA_WIDTH  oldest buffered result.
REQ-012 m_ready  input  1  downstream accepts m_data when m_valid=1.
REQ-013 fill_level  output  $clog2(DEPTH)+1  entries currently in FIFO.
REQ-014 in_flight  output  $clog2(DEPTH)+1  issued operations whose result has not yet returned.
REQ-015 overflow  output  1  sticky: a result arrived with FIFO full and no pop that cycle.
REQ-016 result_count  output  CNT_WIDTH  results accepted into FIFO since reset, wraps at 2^CNT_WIDTH.

Function
REQ-017 FIFO SHALL push out when output_valid=1 and (fill_level<DEPTH or pop in same cycle).
REQ-018 Pop SHALL occur when m_valid=1 and m_ready=1; m_data SHALL be the head entry, first-word fall-through, no added latency.
REQ-019 m_valid SHALL equal (fill_level!=0); push into empty FIFO SHALL make m_valid=1 the next cycle.
REQ-020 Simultaneous push and pop SHALL leave fill_level unchanged, including when full or when fill_level=1.
REQ-021 Read/write pointers SHALL wrap from DEPTH-1 to 0.
REQ-022 in_flight SHALL increment on inputs_valid, decrement on output_valid, unchanged when both or neither.
REQ-023 output_valid with in_flight=0 and inputs_valid=0 SHALL hold in_flight at 0 (no underflow); result still pushed per REQ-017.
REQ-024 inputs_valid with in_flight=DEPTH SHALL saturate in_flight at DEPTH.
REQ-025 issue_ok SHALL be combinational from registers: (fill_level + in_flight) < DEPTH; ignores same-cycle pop.
REQ-026 Drop case (output_valid=1, FIFO full, no pop): result discarded, FIFO unchanged, overflow set next cycle and held until reset.
REQ-027 result_count SHALL increment by 1 per successful push only; wraps to 0.
REQ-028 Driver honoring issue_ok SHALL never cause overflow for any adder latency.

Reset
REQ-029 reset=0 SHALL asynchronously clear pointers, fill_level, in_flight, overflow, result_count; m_valid=0, issue_ok=1, m_data=0.
REQ-030 Reset asserted mid-operation SHALL discard buffered and in-flight results; results arriving after deassertion with in_flight=0 handled per REQ-023.
REQ-031 FIFO storage need not be reset; m_data SHALL read 0 while fill_level=0.

Verification
REQ-032 Issue 4 ops (DEPTH=4), m_ready=0 -> issue_ok=0 after 4th issue, in_flight=4; after 4 results fill_level=4, in_flight=0, issue_ok=0.
REQ-033 Results 0x1,0x2,0x3 pushed, then m_ready=1 -> m_data 0x1,0x2,0x3 in consecutive cycles, m_valid low after third pop, result_count=3.
REQ-034 FIFO full, output_valid=1 with m_ready=1 same cycle -> push and pop, fill_level stays 4, overflow=0.
REQ-035 FIFO full, output_valid=1, m_ready=0 -> result dropped, overflow=1 next cycle and sticky, result_count unchanged.
REQ-036 Push 6 results with interleaved pops -> pointer wrap, data order preserved.
REQ-037 reset=0 asserted mid-stream with fill_level=2, in_flight=1 -> all counters 0, m_valid=0, issue_ok=1 immediately without clock edge.
